// File: rtl/pix_rx_monitor_if.sv
// Pixel stream entering the sink-side monitor: 8-bit RGB plus 3-bit ctrl
// (ctrl[0]=hsync, ctrl[1]=vsync, ctrl[2]=de, all active-high).
interface pix_rx_monitor_if;
  logic [7:0] in_r;
  logic [7:0] in_g;
  logic [7:0] in_b;
  logic [2:0] in_c;

  modport master (output in_r, in_g, in_b, in_c);
  modport slave  (input  in_r, in_g, in_b, in_c);
endinterface

// File: rtl/pix_rx_monitor.sv
// Sink-side monitor for the processed pixel stream. Recovers x/y from the
// ctrl bits, checks line/frame geometry, accumulates a bounding box and a
// count of green-keyed pixels, and publishes the results once per frame.
module pix_rx_monitor #(
  parameter int KEY_MARGIN = 32,
  parameter int MAX_W      = 1280,
  parameter int MAX_H      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  pix_rx_monitor_if.slave       pix,
  output logic [10:0]           box_xmin,
  output logic [10:0]           box_xmax,
  output logic [10:0]           box_ymin,
  output logic [10:0]           box_ymax,
  output logic                  box_empty,
  output logic [20:0]           mark_cnt,
  output logic [10:0]           frm_width,
  output logic [10:0]           frm_height,
  output logic                  frm_err,
  output logic                  frm_valid
);

  localparam logic [9:0]  KEY_M   = 10'(KEY_MARGIN);
  localparam logic [10:0] W_LIMIT = 11'(MAX_W);
  localparam logic [10:0] H_LIMIT = 11'(MAX_H);
  localparam logic [10:0] XY_SAT  = 11'h7FF;
  localparam logic [20:0] CNT_SAT = 21'h1F_FFFF;

  typedef enum logic [1:0] {ST_SEEK, ST_BLANK, ST_LINE} state_t;

  // Bit order matches in_c so the port can be cast directly.
  typedef struct packed {
    logic de;
    logic vs;
    logic hs;
  } ctrl_t;

  // Everything that is rebuilt from scratch for every frame.
  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] ref_w;
    logic        err;
    logic        any;
    logic [20:0] cnt;
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [10:0] ymin;
    logic [10:0] ymax;
  } acc_t;

  localparam acc_t ACC_CLR = '0;

  // Stage 1 signals
  ctrl_t      c_d1;
  logic       vs_d2, de_d2;
  logic       mark_d1;
  logic [9:0] r10, g10, b10;
  logic       key_hit;

  // Stage 2 signals
  state_t state_q, state_d;
  acc_t   acc_q, acc_n, acc_d;
  logic   vs_rise, de_fall, pix_ok, proto_err;
  logic   do_pix, do_close, publish, clear;

  // Result registers
  logic [10:0] box_xmin_q, box_xmax_q, box_ymin_q, box_ymax_q;
  logic        box_empty_q;
  logic [20:0] mark_cnt_q;
  logic [10:0] frm_width_q, frm_height_q;
  logic        frm_err_q;
  logic        pub_q, frm_valid_q;

  // Colour key: green must exceed both red and blue by the margin; widened
  // to 10 bits so the sum cannot wrap.
  assign r10     = {2'b00, pix.in_r};
  assign g10     = {2'b00, pix.in_g};
  assign b10     = {2'b00, pix.in_b};
  assign key_hit = (g10 >= r10 + KEY_M) && (g10 >= b10 + KEY_M);

  // Stage 1: register ctrl and the key decision, keep one more ctrl tap for edges.
  // NOTE: every register, including pipeline taps, is cleared by reset so the
  // first cycles after reset cannot fake a vsync or de edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from pre-edge values.
      c_d1    <= '0;
      vs_d2   <= 1'b0;
      de_d2   <= 1'b0;
      mark_d1 <= 1'b0;
    end else begin
      c_d1    <= ctrl_t'(pix.in_c);
      vs_d2   <= c_d1.vs;
      de_d2   <= c_d1.de;
      mark_d1 <= key_hit;
    end
  end

  assign vs_rise   = c_d1.vs & ~vs_d2;
  assign de_fall   = ~c_d1.de & de_d2;
  assign pix_ok    = c_d1.de & ~c_d1.vs;
  assign proto_err = c_d1.de & (c_d1.vs | c_d1.hs);

  // Stage 2: frame FSM next state plus accumulator update.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    state_d  = state_q;
    acc_n    = acc_q;
    do_pix   = 1'b0;
    do_close = 1'b0;
    publish  = 1'b0;
    clear    = 1'b0;

    unique case (state_q)
      ST_SEEK: begin
        // Mid-frame on entry: wait for a frame start, never publish this one.
        if (vs_rise) begin
          state_d = ST_BLANK;
          clear   = 1'b1;
        end
      end
      ST_BLANK: begin
        do_pix  = pix_ok;
        publish = vs_rise;
        if (pix_ok) state_d = ST_LINE;
      end
      ST_LINE: begin
        do_pix  = pix_ok;
        publish = vs_rise;
        if (de_fall || vs_rise) begin
          do_close = 1'b1;
          state_d  = ST_BLANK;
        end
      end
      default: state_d = ST_SEEK;
    endcase

    if (state_q != ST_SEEK && proto_err) acc_n.err = 1'b1;

    // Pixel at the current x; x is 0 whenever a line starts from BLANK.
    if (do_pix) begin
      acc_n.x = (acc_q.x == XY_SAT) ? XY_SAT : acc_q.x + 11'd1;
      if (mark_d1) begin
        acc_n.cnt = (acc_q.cnt == CNT_SAT) ? CNT_SAT : acc_q.cnt + 21'd1;
        if (!acc_q.any) begin
          acc_n.any  = 1'b1;
          acc_n.xmin = acc_q.x;
          acc_n.xmax = acc_q.x;
          acc_n.ymin = acc_q.y;
          acc_n.ymax = acc_q.y;
        end else begin
          if (acc_q.x < acc_q.xmin) acc_n.xmin = acc_q.x;
          if (acc_q.x > acc_q.xmax) acc_n.xmax = acc_q.x;
          if (acc_q.y > acc_q.ymax) acc_n.ymax = acc_q.y;
        end
      end
    end

    // Line close: the first line sets the reference width, later lines must match.
    if (do_close) begin
      if (acc_q.y == 11'd0)            acc_n.ref_w = acc_q.x;
      else if (acc_q.x != acc_q.ref_w) acc_n.err   = 1'b1;
      if (acc_q.x > W_LIMIT)           acc_n.err   = 1'b1;
      acc_n.y = (acc_q.y == XY_SAT) ? XY_SAT : acc_q.y + 11'd1;
      if (acc_n.y > H_LIMIT)           acc_n.err   = 1'b1;
      acc_n.x = 11'd0;
    end

    // The publish snapshot reads acc_n; the next frame starts from a clean slate.
    acc_d = (clear || publish) ? ACC_CLR : acc_n;
  end

  // Stage 2: FSM state and accumulators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SEEK;
      acc_q   <= ACC_CLR;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Result registers load on the publish cycle; frm_valid follows one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_xmin_q   <= '0;
      box_xmax_q   <= '0;
      box_ymin_q   <= '0;
      box_ymax_q   <= '0;
      box_empty_q  <= 1'b1;
      mark_cnt_q   <= '0;
      frm_width_q  <= '0;
      frm_height_q <= '0;
      frm_err_q    <= 1'b0;
      pub_q        <= 1'b0;
      frm_valid_q  <= 1'b0;
    end else begin
      pub_q       <= publish;
      frm_valid_q <= pub_q;
      if (publish) begin
        box_xmin_q   <= acc_n.any ? acc_n.xmin : 11'd0;
        box_xmax_q   <= acc_n.any ? acc_n.xmax : 11'd0;
        box_ymin_q   <= acc_n.any ? acc_n.ymin : 11'd0;
        box_ymax_q   <= acc_n.any ? acc_n.ymax : 11'd0;
        box_empty_q  <= ~acc_n.any;
        mark_cnt_q   <= acc_n.cnt;
        frm_width_q  <= acc_n.ref_w;
        frm_height_q <= acc_n.y;
        frm_err_q    <= acc_n.err;
      end
    end
  end

  assign box_xmin   = box_xmin_q;
  assign box_xmax   = box_xmax_q;
  assign box_ymin   = box_ymin_q;
  assign box_ymax   = box_ymax_q;
  assign box_empty  = box_empty_q;
  assign mark_cnt   = mark_cnt_q;
  assign frm_width  = frm_width_q;
  assign frm_height = frm_height_q;
  assign frm_err    = frm_err_q;
  assign frm_valid  = frm_valid_q;

endmodule
